// File: rtl/dispense_pkg.sv
// Shared types and constants for the dispenser vend sequencer.
// Slot numbering: 0 = none, 1-3 = DC augers, 4-7 = stepper carousel.
package dispense_pkg;

    localparam int SEL_W = 3;
    localparam int AMT_W = 2;

    localparam logic [SEL_W-1:0] SLOT_NONE     = 3'd0;
    localparam logic [SEL_W-1:0] SLOT_DC_MAX   = 3'd3;
    localparam logic [SEL_W-1:0] SLOT_STEP_MIN = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP,
        DC_RUN,
        SETTLE
    } state_t;

    function automatic logic [2:0] dc_onehot(input logic [SEL_W-1:0] sel);
        logic [2:0] result;
        result = 3'b000;
        if (sel != SLOT_NONE && sel <= SLOT_DC_MAX) begin
            result = 3'b001 << (sel - 3'd1);
        end
        return result;
    endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Stepper pulse generator: while enabled, emits STEP_HALF cycles high then STEP_HALF low.
// step_done strobes on the edge that closes each full high+low period.
module step_pulse_gen #(
    parameter int STEP_HALF = 6000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic step,
    output logic step_done
);

    localparam int CW = $clog2(2 * STEP_HALF + 1);
    localparam logic [CW-1:0] HALF   = CW'(STEP_HALF);
    localparam logic [CW-1:0] PERIOD = CW'(2 * STEP_HALF);

    // cnt = cycles of the current period already presented on step; 0 means not running.
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (cnt == '0 || cnt == PERIOD) begin
            cnt  <= CW'(1);
            step <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            step <= (cnt < HALF);
        end
    end

    assign step_done = (cnt == PERIOD);

endmodule

// File: rtl/dispense_sequencer.sv
// Sequences one vend: DC auger for a timed run (slots 1-3) or stepper carousel for a
// counted number of steps (slots 4-7), then a motors-off settle before done.
module dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int STEP_HALF      = 6000,
    parameter int STEPS_PER_UNIT = 200,
    parameter int DC_CYCLES      = 12000000,
    parameter int DIR_SETUP      = 1200,
    parameter int SETTLE_CYC     = 1200000
) (
    input  logic             clk_x1,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel_state,
    input  logic [AMT_W-1:0] amount,
    input  logic             candy_flag,
    input  logic             abort,
    output logic             sig_received,
    output logic             err,
    output logic             busy,
    output logic             done,
    output logic             step,
    output logic             dir,
    output logic [2:0]       dc_motor,
    output state_t           state
);

    // One shared timer serves SETUP, DC_RUN and SETTLE, so size it for the longest.
    localparam int TMAX_A = (3 * DC_CYCLES > SETTLE_CYC) ? 3 * DC_CYCLES : SETTLE_CYC;
    localparam int TMAX   = (TMAX_A > DIR_SETUP) ? TMAX_A : DIR_SETUP;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int SW     = $clog2(3 * STEPS_PER_UNIT + 1);

    state_t           next_state;
    logic             flag_q;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic [AMT_W-1:0] amt_q, amt_n;
    logic [TW-1:0]    timer, timer_n;
    logic [SW-1:0]    steps, steps_n;
    logic             ack_n, err_n, done_n, dir_n;
    logic             rise, step_en, step_done;
    logic [TW-1:0]    dc_total;
    logic [SW-1:0]    step_total;

    assign rise       = candy_flag & ~flag_q;
    assign dc_total   = TW'(amt_q) * TW'(DC_CYCLES);
    assign step_total = SW'(amt_q) * SW'(STEPS_PER_UNIT);
    assign step_en    = (next_state == STEP);

    step_pulse_gen #(.STEP_HALF(STEP_HALF)) u_step_pulse_gen (
        .clk       (clk_x1),
        .rst       (rst),
        .enable    (step_en),
        .step      (step),
        .step_done (step_done)
    );

    always_comb begin
        next_state = state;
        timer_n    = timer;
        steps_n    = steps;
        sel_n      = sel_q;
        amt_n      = amt_q;
        ack_n      = 1'b0;
        err_n      = 1'b0;
        done_n     = 1'b0;
        dir_n      = dir;
        case (state)
            IDLE: begin
                if (rise) begin
                    if (sel_state != SLOT_NONE && amount != '0) begin
                        sel_n   = sel_state;
                        amt_n   = amount;
                        ack_n   = 1'b1;
                        timer_n = '0;
                        steps_n = '0;
                        if (sel_state >= SLOT_STEP_MIN) begin
                            dir_n      = sel_state[0];
                            next_state = SETUP;
                        end else begin
                            next_state = DC_RUN;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (timer == TW'(DIR_SETUP - 1)) begin
                    timer_n    = '0;
                    next_state = STEP;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            STEP: begin
                if (step_done) begin
                    if (steps == step_total - SW'(1)) begin
                        timer_n    = '0;
                        next_state = SETTLE;
                    end else begin
                        steps_n = steps + SW'(1);
                    end
                end
            end
            DC_RUN: begin
                if (timer == dc_total - TW'(1)) begin
                    timer_n    = '0;
                    next_state = SETTLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            SETTLE: begin
                if (timer == TW'(SETTLE_CYC - 1)) begin
                    done_n     = 1'b1;
                    next_state = IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: next_state = IDLE;
        endcase
        // abort wins over any counter expiring in the same cycle
        if (abort && state != IDLE) begin
            next_state = IDLE;
            done_n     = 1'b0;
        end
    end

    always_ff @(posedge clk_x1) begin
        if (rst) begin
            state        <= IDLE;
            flag_q       <= 1'b1;
            sel_q        <= '0;
            amt_q        <= '0;
            timer        <= '0;
            steps        <= '0;
            sig_received <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dir          <= 1'b0;
            dc_motor     <= 3'b000;
        end else begin
            state        <= next_state;
            flag_q       <= candy_flag;
            sel_q        <= sel_n;
            amt_q        <= amt_n;
            timer        <= timer_n;
            steps        <= steps_n;
            sig_received <= ack_n;
            err          <= err_n;
            busy         <= (next_state != IDLE);
            done         <= done_n;
            dir          <= dir_n;
            dc_motor     <= (next_state == DC_RUN) ? dc_onehot(sel_n) : 3'b000;
        end
    end

endmodule
